// File: rtl/m00_read_burst_splitter.sv
// Splits AXI4 read bursts of up to 256 beats into sub-bursts of at most 16 beats
// and merges the returned R beats back into one burst with the original ID and RLAST.
module m00_read_burst_splitter #(
    parameter int ADDR_WIDTH = 33,
    parameter int DATA_WIDTH = 256,
    parameter int ID_WIDTH   = 3,
    parameter int CMD_DEPTH  = 4
) (
    input  logic                  aclk,
    input  logic                  areset,
    input  logic [ID_WIDTH-1:0]   s_axi_arid,
    input  logic [ADDR_WIDTH-1:0] s_axi_araddr,
    input  logic [7:0]            s_axi_arlen,
    input  logic [2:0]            s_axi_arsize,
    input  logic [1:0]            s_axi_arburst,
    input  logic [3:0]            s_axi_arcache,
    input  logic [2:0]            s_axi_arprot,
    input  logic [3:0]            s_axi_arqos,
    input  logic                  s_axi_arvalid,
    output logic                  s_axi_arready,
    output logic [ID_WIDTH-1:0]   s_axi_rid,
    output logic [DATA_WIDTH-1:0] s_axi_rdata,
    output logic [1:0]            s_axi_rresp,
    output logic                  s_axi_rlast,
    output logic                  s_axi_rvalid,
    input  logic                  s_axi_rready,
    output logic [ADDR_WIDTH-1:0] m_axi_araddr,
    output logic [3:0]            m_axi_arlen,
    output logic [2:0]            m_axi_arsize,
    output logic [1:0]            m_axi_arburst,
    output logic [3:0]            m_axi_arcache,
    output logic [2:0]            m_axi_arprot,
    output logic [3:0]            m_axi_arqos,
    output logic                  m_axi_arvalid,
    input  logic                  m_axi_arready,
    input  logic [DATA_WIDTH-1:0] m_axi_rdata,
    input  logic [1:0]            m_axi_rresp,
    input  logic                  m_axi_rlast,
    input  logic                  m_axi_rvalid,
    output logic                  m_axi_rready
);

    localparam int              PTR_W   = (CMD_DEPTH > 1) ? $clog2(CMD_DEPTH) : 1;
    localparam logic [PTR_W:0]  DEPTH_C = (PTR_W + 1)'(CMD_DEPTH);
    localparam logic [PTR_W:0]  CNT_ONE = (PTR_W + 1)'(1);
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
    localparam logic [1:0]      BURST_INCR = 2'b01;

    typedef enum logic [0:0] {IDLE, ISSUE} ar_state_t;

    ar_state_t state, state_next;
    logic      init_done;

    logic [ADDR_WIDTH-1:0] addr_r;
    logic [7:0]            rem_r;
    logic [2:0]            size_r;
    logic [1:0]            burst_r;
    logic [3:0]            cache_r;
    logic [2:0]            prot_r;
    logic [3:0]            qos_r;

    logic [ID_WIDTH-1:0] fifo_id   [CMD_DEPTH];
    logic [3:0]          fifo_nsub [CMD_DEPTH];
    logic [PTR_W-1:0]    wr_ptr, rd_ptr;
    logic [PTR_W:0]      count;
    logic [3:0]          sub_cnt;

    logic cmd_full, hv, push, pop, m_ar_hs, r_hs, last_sub;

    // INCR sub-bursts restart on a size-aligned address one full 16-beat stride ahead.
    function automatic logic [ADDR_WIDTH-1:0] next_addr(
        input logic [ADDR_WIDTH-1:0] addr,
        input logic [2:0]            size,
        input logic [1:0]            burst
    );
        logic [ADDR_WIDTH-1:0] mask;
        logic [ADDR_WIDTH-1:0] step;
        mask = (ADDR_WIDTH'(1) << size) - ADDR_WIDTH'(1);
        step = ADDR_WIDTH'(16) << size;
        if (burst == BURST_INCR) begin
            return (addr & ~mask) + step;
        end
        return addr;
    endfunction

    function automatic logic [3:0] clamp_len(input logic [7:0] rem);
        return (rem > 8'd15) ? 4'd15 : rem[3:0];
    endfunction

    assign cmd_full = (count == DEPTH_C);
    assign hv       = (count != '0);
    assign push     = s_axi_arvalid && s_axi_arready;
    assign m_ar_hs  = m_axi_arvalid && m_axi_arready;

    always_ff @(posedge aclk) begin
        if (areset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next    = state;
        s_axi_arready = 1'b0;
        m_axi_arvalid = 1'b0;
        case (state)
            IDLE: begin
                s_axi_arready = init_done && !cmd_full;
                if (s_axi_arvalid && init_done && !cmd_full) begin
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                m_axi_arvalid = 1'b1;
                if (m_axi_arready && (rem_r <= 8'd15)) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (push) begin
            addr_r  <= s_axi_araddr;
            rem_r   <= s_axi_arlen;
            size_r  <= s_axi_arsize;
            burst_r <= s_axi_arburst;
            cache_r <= s_axi_arcache;
            prot_r  <= s_axi_arprot;
            qos_r   <= s_axi_arqos;
        end else if (m_ar_hs && (rem_r > 8'd15)) begin
            rem_r  <= rem_r - 8'd16;
            addr_r <= next_addr(addr_r, size_r, burst_r);
        end
    end

    assign m_axi_araddr  = addr_r;
    assign m_axi_arlen   = clamp_len(rem_r);
    assign m_axi_arsize  = size_r;
    assign m_axi_arburst = burst_r;
    assign m_axi_arcache = cache_r;
    assign m_axi_arprot  = prot_r;
    assign m_axi_arqos   = qos_r;

    // R merge: beats flow straight through, gated by having a tracked burst at the head.
    assign last_sub     = (sub_cnt == fifo_nsub[rd_ptr]);
    assign r_hs         = m_axi_rvalid && s_axi_rready && hv;
    assign pop          = r_hs && m_axi_rlast && last_sub;
    assign s_axi_rvalid = m_axi_rvalid && hv;
    assign m_axi_rready = s_axi_rready && hv;
    assign s_axi_rdata  = m_axi_rdata;
    assign s_axi_rresp  = m_axi_rresp;
    assign s_axi_rid    = fifo_id[rd_ptr];
    assign s_axi_rlast  = m_axi_rlast && last_sub;

    always_ff @(posedge aclk) begin
        if (push) begin
            fifo_id[wr_ptr]   <= s_axi_arid;
            fifo_nsub[wr_ptr] <= s_axi_arlen[7:4];
        end
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            init_done <= 1'b0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            sub_cnt   <= '0;
        end else begin
            init_done <= 1'b1;
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
            if (r_hs && m_axi_rlast) begin
                sub_cnt <= last_sub ? 4'd0 : sub_cnt + 4'd1;
            end
        end
    end

endmodule
